// File: rtl/pwm_audio_out.sv
// PCM-to-PWM speaker driver: signed samples queue in a small FIFO, pass through a
// shift-based volume stage and become an offset-binary duty level latched at period boundaries.
module pwm_audio_out #(
  parameter int PWM_W      = 8,
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int VOL_W      = 3
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic [VOL_W-1:0]              vol_in,
  input  logic                          mode_in,
  input  logic                          enable_in,
  output logic                          pwm_out,
  output logic [PWM_W-1:0]              level_out,
  output logic                          period_out,
  output logic                          underrun_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_fifo_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
  localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1);
  localparam logic [PWM_W-1:0] MID      = {1'b1, {(PWM_W-1){1'b0}}};

  logic [SAMPLE_W-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]              wr_ptr;
  logic [AW-1:0]              rd_ptr;
  logic [AW:0]                count;
  logic [PWM_W-1:0]           counter;
  logic [PWM_W-1:0]           level;
  logic                       pwm_q;

  logic                       full;
  logic                       empty;
  logic                       boundary;
  logic                       push;
  logic                       pop;
  logic [VOL_W-1:0]           shift;
  logic signed [SAMPLE_W-1:0] scaled;
  logic [PWM_W-1:0]           t;
  logic [PWM_W-1:0]           new_level;

  // Handshake: a sample transfers on any clk_in edge where valid_in and ready_out are both
  // high; ready_out reflects occupancy only, so a full FIFO refuses even if a pop coincides.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign ready_out = !full;
  assign push      = valid_in && !full;
  assign boundary  = enable_in && (counter == '1);
  assign pop       = boundary && !empty;

  // Volume is an arithmetic shift; the top PWM_W bits of the scaled sample become the duty.
  assign shift     = '1 - vol_in;
  assign scaled    = $signed(mem[rd_ptr]) >>> shift;
  assign t         = scaled[SAMPLE_W-1 -: PWM_W];
  assign new_level = {~t[PWM_W-1], t[PWM_W-2:0]};

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= sample_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      counter <= '0;
      level   <= MID;
      pwm_q   <= 1'b0;
    end else begin
      counter <= enable_in ? counter + PWM_ONE : '0;
      pwm_q   <= enable_in && (counter < level);
      if (pop) begin
        level <= new_level;
      end else if (boundary && mode_in) begin
        level <= MID;
      end
    end
  end

  assign pwm_out        = pwm_q;
  assign level_out      = level;
  assign period_out     = boundary;
  assign underrun_out   = boundary && empty;
  assign count_fifo_out = count;

endmodule

// File: tb/tb_pwm_audio_out.sv
// Directed bench for pwm_audio_out: reset, duty levels, volume, FIFO ordering/full, underrun
// policies and mid-period reset, each against hand-computed values.
module tb_pwm_audio_out;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [15:0] sample_in;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  vol_in;
  logic        mode_in;
  logic        enable_in;
  logic        pwm_out;
  logic [7:0]  level_out;
  logic        period_out;
  logic        underrun_out;
  logic [2:0]  count_fifo_out;

  int errors = 0;
  int checks = 0;

  pwm_audio_out #(.PWM_W(8), .SAMPLE_W(16), .FIFO_DEPTH(4), .VOL_W(3)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .sample_in(sample_in), .valid_in(valid_in),
    .ready_out(ready_out), .vol_in(vol_in), .mode_in(mode_in), .enable_in(enable_in),
    .pwm_out(pwm_out), .level_out(level_out), .period_out(period_out),
    .underrun_out(underrun_out), .count_fifo_out(count_fifo_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push(input logic [15:0] s);
    sample_in = s;
    valid_in  = 1'b1;
    tick();
    valid_in  = 1'b0;
  endtask

  // Stops with the counter at 0, then queues one sample and restarts the counter.
  task automatic load_and_run(input logic [15:0] s);
    enable_in = 1'b0;
    tick();
    push(s);
    enable_in = 1'b1;
  endtask

  // Advances to just after the next boundary edge; optionally offers a push in the boundary cycle.
  task automatic wait_boundary(input bit do_push, input logic [15:0] s, output logic urun);
    int n = 0;
    while (period_out !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check("boundary_seen", {31'b0, period_out}, 32'd1);
    urun = underrun_out;
    if (do_push) begin
      sample_in = s;
      valid_in  = 1'b1;
    end
    tick();
    valid_in = 1'b0;
  endtask

  task automatic measure_high(output int highs);
    highs = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (pwm_out === 1'b1) highs++;
    end
  endtask

  logic [15:0] fifo_samples [5];
  logic [7:0]  fifo_levels  [5];

  initial begin
    logic urun;
    int   highs;
    int   n;

    rst_in    = 1'b0;
    valid_in  = 1'b1;
    sample_in = 16'h1234;
    vol_in    = 3'd7;
    mode_in   = 1'b0;
    enable_in = 1'b0;

    // Reset held for 3 cycles with valid_in high: nothing may be queued.
    repeat (3) begin
      tick();
      check("rst_period", {31'b0, period_out}, 32'd0);
    end
    check("rst_pwm", {31'b0, pwm_out}, 32'd0);
    check("rst_level", {24'b0, level_out}, 32'h80);
    check("rst_count", {29'b0, count_fifo_out}, 32'd0);
    check("rst_ready", {31'b0, ready_out}, 32'd1);
    check("rst_underrun", {31'b0, underrun_out}, 32'd0);
    valid_in = 1'b0;
    tick();
    rst_in = 1'b1;
    tick();
    check("post_rst_count", {29'b0, count_fifo_out}, 32'd0);

    // Midscale.
    load_and_run(16'h0000);
    wait_boundary(1'b0, 16'h0, urun);
    check("mid_underrun", {31'b0, urun}, 32'd0);
    check("mid_level", {24'b0, level_out}, 32'h80);
    measure_high(highs);
    check("mid_high", highs, 32'd128);

    // Extremes.
    load_and_run(16'h7FFF);
    wait_boundary(1'b0, 16'h0, urun);
    check("max_level", {24'b0, level_out}, 32'hFF);
    measure_high(highs);
    check("max_high", highs, 32'd255);

    load_and_run(16'h8000);
    wait_boundary(1'b0, 16'h0, urun);
    check("min_level", {24'b0, level_out}, 32'h00);
    measure_high(highs);
    check("min_high", highs, 32'd0);

    // Volume: shift 1 on a positive sample, shift 2 on the most negative sample.
    vol_in = 3'd6;
    load_and_run(16'h4000);
    wait_boundary(1'b0, 16'h0, urun);
    vol_in = 3'd0;
    check("vol6_level", {24'b0, level_out}, 32'hA0);
    measure_high(highs);
    check("vol6_high", highs, 32'd160);

    vol_in = 3'd5;
    load_and_run(16'h8000);
    wait_boundary(1'b0, 16'h0, urun);
    check("vol5_neg_level", {24'b0, level_out}, 32'h60);
    measure_high(highs);
    check("vol5_neg_high", highs, 32'd96);

    // Disabled counter forces the output low.
    enable_in = 1'b0;
    tick();
    tick();
    check("disabled_pwm", {31'b0, pwm_out}, 32'd0);

    // FIFO full, ordering, simultaneous push/pop, underrun policies.
    vol_in = 3'd7;
    fifo_samples[0] = 16'h1000; fifo_levels[0] = 8'h90;
    fifo_samples[1] = 16'hF000; fifo_levels[1] = 8'h70;
    fifo_samples[2] = 16'h7FFF; fifo_levels[2] = 8'hFF;
    fifo_samples[3] = 16'h0100; fifo_levels[3] = 8'h81;
    fifo_samples[4] = 16'h5555; fifo_levels[4] = 8'hD5;
    for (int i = 0; i < 5; i++) begin
      sample_in = fifo_samples[i];
      valid_in  = 1'b1;
      check($sformatf("fill_ready_%0d", i), {31'b0, ready_out}, (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    valid_in = 1'b0;
    check("full_count", {29'b0, count_fifo_out}, 32'd4);
    check("full_ready", {31'b0, ready_out}, 32'd0);

    enable_in = 1'b1;
    // Push offered while full in the pop cycle must be refused.
    wait_boundary(1'b1, 16'h2000, urun);
    check("pop0_level", {24'b0, level_out}, {24'b0, fifo_levels[0]});
    check("pop0_underrun", {31'b0, urun}, 32'd0);
    check("pop0_count", {29'b0, count_fifo_out}, 32'd3);
    // Push and pop together on a non-full FIFO keep occupancy.
    wait_boundary(1'b1, 16'h2000, urun);
    check("pop1_level", {24'b0, level_out}, {24'b0, fifo_levels[1]});
    check("pop1_count", {29'b0, count_fifo_out}, 32'd3);
    wait_boundary(1'b0, 16'h0, urun);
    check("pop2_level", {24'b0, level_out}, {24'b0, fifo_levels[2]});
    wait_boundary(1'b0, 16'h0, urun);
    check("pop3_level", {24'b0, level_out}, {24'b0, fifo_levels[3]});
    wait_boundary(1'b0, 16'h0, urun);
    check("pop4_level", {24'b0, level_out}, 32'hA0);
    check("pop4_underrun", {31'b0, urun}, 32'd0);
    check("pop4_count", {29'b0, count_fifo_out}, 32'd0);
    wait_boundary(1'b0, 16'h0, urun);
    check("urun_hold_pulse", {31'b0, urun}, 32'd1);
    check("urun_hold_level", {24'b0, level_out}, 32'hA0);
    tick();
    check("urun_one_cycle", {31'b0, underrun_out}, 32'd0);
    mode_in = 1'b1;
    wait_boundary(1'b0, 16'h0, urun);
    check("urun_mid_pulse", {31'b0, urun}, 32'd1);
    check("urun_mid_level", {24'b0, level_out}, 32'h80);
    mode_in = 1'b0;

    // Mid-operation reset with 3 entries queued and counter at 100.
    enable_in = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) push(16'h7FFF);
    enable_in = 1'b1;
    wait_boundary(1'b0, 16'h0, urun);
    check("pre_rst_level", {24'b0, level_out}, 32'hFF);
    check("pre_rst_count", {29'b0, count_fifo_out}, 32'd3);
    repeat (100) tick();
    check("pre_rst_pwm", {31'b0, pwm_out}, 32'd1);
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check("mrst_count", {29'b0, count_fifo_out}, 32'd0);
    check("mrst_level", {24'b0, level_out}, 32'h80);
    check("mrst_pwm", {31'b0, pwm_out}, 32'd0);
    check("mrst_ready", {31'b0, ready_out}, 32'd1);
    n = 0;
    while (period_out !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check("mrst_counter_restart", n, 32'd255);
    check("mrst_underrun", {31'b0, underrun_out}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_audio_out.md
Name: pwm_audio_out

Overview:
- Parametrised successor to the 8-bit free-running PWM speaker driver.
- Accepts signed PCM samples through a valid/ready handshake into a small FIFO, applies a shift-based volume stage, converts to offset binary, and drives a single-bit PWM output.
- The duty level updates only at PWM period boundaries, so the output is glitch-free.
- Sits between the FIR/delay output stage and the aud_pwm pin; reports underrun when the upstream pipeline misses a period.

Parameters:
- PWM_W, 8: PWM resolution in bits; period is 2^PWM_W clocks.
- SAMPLE_W, 16: width of the signed input sample; must be >= PWM_W.
- FIFO_DEPTH, 4: sample FIFO entries; power of two, >= 2.
- VOL_W, 3: volume control width; max code means unity gain.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  synchronous, active-low reset.
- sample_in  input  SAMPLE_W  signed two's-complement PCM sample.
- valid_in  input  1  sample_in valid.
- ready_out  output  1  FIFO can accept; high iff FIFO not full.
- vol_in  input  VOL_W  volume; arithmetic right shift = (2^VOL_W-1) - vol_in.
- mode_in  input  1  underrun policy: 0 = hold last level, 1 = force midscale.
- enable_in  input  1  run the PWM counter and pop samples.
- pwm_out  output  1  registered PWM bit.
- level_out  output  PWM_W  current duty level (offset binary), for debug.
- period_out  output  1  one-cycle pulse on the last count of each period.
- underrun_out  output  1  one-cycle pulse when a boundary finds the FIFO empty.
- count_fifo_out  output  clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (rst_in low at a clk_in edge) sets:
  - counter = 0, FIFO empty, level = 2^(PWM_W-1);
  - pwm_out = 0, period_out = 0, underrun_out = 0;
  - ready_out = 1 combinationally once the FIFO is empty.
- Reset asserted mid-period discards FIFO contents and the in-flight level.
- Push: on valid_in && ready_out, the sample is written; occupancy +1.
- ready_out depends only on occupancy. A full FIFO refuses a push even when a pop occurs in the same cycle.
- Counter:
  - When enable_in = 1, the counter increments each cycle and wraps from 2^PWM_W-1 to 0.
  - When enable_in = 0, the counter is held at 0, pwm_out = 0, no pops occur, and pushes continue.
- Boundary is defined as enable_in && counter == 2^PWM_W-1. At a boundary, period_out = 1 that cycle and:
  - If the FIFO is non-empty: pop the head and compute the new level:
    - v = sample >>> shift (sign-preserving);
    - t = v[SAMPLE_W-1 -: PWM_W];
    - level <= {~t[PWM_W-1], t[PWM_W-2:0]}.
  - If the FIFO is empty: underrun_out = 1 for one cycle, and level <= level (mode_in = 0) or 2^(PWM_W-1) (mode_in = 1).
  - The new level applies from counter = 0 of the next period.
- Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged, FIFO order preserved.
- vol_in is sampled only at the pop cycle; changes between boundaries have no effect.
- Output: pwm_out <= enable_in && (counter < level), giving one cycle of latency from the counter.
  - Level 0 gives a constant-low output.
  - Level 2^PWM_W-1 gives 2^PWM_W-1 high cycles per period.
- The top level keeps aud_pwm = pwm_out ? Z : 0 outside this block.

Test Plan:
- Reset: hold rst_in = 0 for 3 cycles with valid_in = 1 -> pwm_out = 0, level_out = 0x80, count_fifo_out = 0, ready_out = 1, no pulses.
- Midscale (PWM_W = 8, SAMPLE_W = 16), vol_in = 7: push 0x0000, enable -> after the first boundary, level_out = 0x80 and pwm_out is high for exactly 128 of each 256 cycles.
- Extremes, vol_in = 7:
  - push 0x7FFF -> level 0xFF, 255 high cycles per period;
  - push 0x8000 -> level 0x00, pwm_out never high.
- Volume, vol_in = 6: push 0x4000 -> shift 1, t = 0x20, level_out = 0xA0, 160 high cycles per period.
- FIFO full / underrun, enable_in = 0:
  - push 5 samples back-to-back -> 4 accepted, ready_out = 0 after the 4th, the 5th is held off;
  - enable -> 4 pops in order at 4 consecutive boundaries;
  - the 5th boundary pulses underrun_out: level is held with mode_in = 0, or becomes 0x80 with mode_in = 1.
- Mid-operation reset: rst_in = 0 for 1 cycle with 3 entries queued and counter at 100 -> next cycle count_fifo_out = 0, counter = 0, level_out = 0x80, pwm_out = 0.
